// File: rtl/seg_scan_mux_pkg.sv
// ============================================================================
//  Module      : seg_scan_mux_pkg
//  Description : Shared constants, types and the leading-zero mask helper
//                for the seven-segment scan multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_mux_pkg;

  // Board geometry: eight digits of four bits each.
  localparam int DIGIT_CNT = 8;
  localparam int NIBBLE_W  = 4;
  localparam int VALUE_W   = DIGIT_CNT * NIBBLE_W;

  // Idle levels of the active-low display outputs.
  localparam logic [DIGIT_CNT-1:0] AN_ALL_OFF = 8'hFF;
  localparam logic                 DP_OFF     = 1'b1;

  // One complete display image: nibbles plus decimal-point requests.
  typedef struct packed {
    logic [VALUE_W-1:0]   value;
    logic [DIGIT_CNT-1:0] dp;
  } disp_word_t;

  // Bit d set means digit d is a leading zero: it and every digit above it
  // are zero. Digit 0 always shows, so bit 0 is never set.
  function automatic logic [DIGIT_CNT-1:0] lz_mask(input logic [VALUE_W-1:0] v);
    logic [DIGIT_CNT-1:0] m;
    logic                 upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    for (int d = DIGIT_CNT - 1; d >= 1; d--) begin
      upper_zero = upper_zero & (v[d*NIBBLE_W +: NIBBLE_W] == 4'd0);
      m[d]       = upper_zero;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
// ============================================================================
//  Module      : seg_scan_mux_if
//  Description : Bus between the display-value producer and the scanner,
//                plus the scanner outputs that feed the segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_mux_if;
  import seg_scan_mux_pkg::*;

  logic [VALUE_W-1:0]   value_in;
  logic [DIGIT_CNT-1:0] dp_in;
  logic [DIGIT_CNT-1:0] digit_en;
  logic                 blank_lz;
  logic                 load;
  logic                 load_ack;
  logic                 frame_start;
  logic [NIBBLE_W-1:0]  nibble_out;
  logic                 dp_out;
  logic [DIGIT_CNT-1:0] an;

  // Producer side: supplies values and controls, observes the scan.
  modport master (
    output value_in, dp_in, digit_en, blank_lz, load,
    input  load_ack, frame_start, nibble_out, dp_out, an
  );

  // Scanner side.
  modport slave (
    input  value_in, dp_in, digit_en, blank_lz, load,
    output load_ack, frame_start, nibble_out, dp_out, an
  );

endinterface

`default_nettype wire

// File: rtl/seg_tick_gen.sv
// ============================================================================
//  Module      : seg_tick_gen
//  Description : Digit-slot prescaler. Pulses tick_o on the last cycle of
//                each slot and flags the anti-ghosting guard window at the
//                start of each slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_tick_gen #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output logic in_guard_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o     = (cnt_q == CNT_MAX);
  assign in_guard_o = (cnt_q < GUARD_END);

  // Free-running slot counter, 0..TICK_DIV-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexed scanner for an 8-digit common-anode
//                seven-segment display. New values are taken through a
//                load/ack handshake and only become visible at a frame
//                boundary so a frame never shows a mix of old and new data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000,
  parameter int GUARD      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_mux_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic tick;
  logic in_guard;
  logic boundary;

  logic [IDX_W-1:0]     idx_q,     idx_d;
  disp_word_t           shadow_q,  shadow_d;
  disp_word_t           pend_q,    pend_d;
  logic                 pending_q, pending_d;

  logic [DIGIT_CNT-1:0] an_q,      an_d;
  logic [NIBBLE_W-1:0]  nib_q,     nib_d;
  logic                 dp_q,      dp_d;
  logic                 ack_q,     ack_d;
  logic                 fs_q,      fs_d;

  logic [DIGIT_CNT-1:0] an_lit;
  logic [DIGIT_CNT-1:0] lz;
  logic                 blank;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .GUARD    (GUARD)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_o     (tick),
    .in_guard_o (in_guard)
  );

  // The last slot of a frame ends here; handover happens on this cycle.
  assign boundary = tick && (idx_q == LAST_IDX);

  // One-hot-low anode pattern for the current digit.
  for (genvar g = 0; g < DIGIT_CNT; g++) begin : g_an_sel
    assign an_lit[g] = (idx_q != IDX_W'(g));
  end

  // Blank when the digit is disabled or it is a suppressed leading zero.
  // Both controls are live inputs; zeros are judged on the visible value.
  assign lz    = lz_mask(shadow_q.value);
  assign blank = ~bus.digit_en[idx_q] | (bus.blank_lz & lz[idx_q]);

  // Digit index advances once per slot and wraps after the last digit.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Load handshake: a load always lands in the pending slot (last wins);
  // the boundary moves the older pending image into the shadow. A load on
  // the boundary cycle therefore stays pending for the following frame.
  always_comb begin
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    fs_d      = boundary;
    if (boundary && pending_q) begin
      shadow_d  = pend_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
    if (bus.load) begin
      pend_d.value = bus.value_in;
      pend_d.dp    = bus.dp_in;
      pending_d    = 1'b1;
    end
  end

  // Next display outputs from the current slot position and shadow image.
  // Guard and blanking gate only the anodes; nibble and dp keep tracking.
  always_comb begin
    an_d  = (in_guard || blank) ? AN_ALL_OFF : an_lit;
    nib_d = shadow_q.value[{idx_q, 2'b00} +: NIBBLE_W];
    dp_d  = ~shadow_q.dp[idx_q];
  end

  // Scan position and value storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  // Registered outputs, one cycle behind the scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_ALL_OFF;
      nib_q <= '0;
      dp_q  <= DP_OFF;
      ack_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      nib_q <= nib_d;
      dp_q  <= dp_d;
      ack_q <= ack_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.nibble_out  = nib_q;
  assign bus.dp_out      = dp_q;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;

endmodule

`default_nettype wire
